mem_bus_bridge: RTL

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: 16-bit CPU memory request to byte-serial external bus bridge.
// Each transaction sends two address bytes and then either sends two data
// bytes (write) or captures two data bytes (read). Every byte waits for a
// handshake edge from the asynchronous external side.
// Optional feature: define BRIDGE_TIMEOUT_EN to abort a transaction that
// stalls in a byte state for TIMEOUT_CYCLES cycles (rsp_err=1).
//
// state   | meaning
// IDLE    | ready for a request
// ADDR_HI | address byte [15:8] on out_bus
// ADDR_LO | address byte [7:0] on out_bus
// WR_HI   | write data byte [15:8] on out_bus
// WR_LO   | write data byte [7:0] on out_bus
// RD_HI   | waiting for read data byte [15:8] on in_bus
// RD_LO   | waiting for read data byte [7:0] on in_bus
// DONE    | one-cycle completion pulse
module mem_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        ard_data_ready,
  input  logic        ard_receive_ready,
  input  logic [7:0]  in_bus,
  output logic [7:0]  out_bus,
  output logic        bus_mar,
  output logic        bus_mdr,
  output logic        bus_we
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO, DONE
  } state_t;

  state_t state, state_nxt;

  // [0],[1] are the synchronizer stages, [2] is the edge-detect history
  logic [2:0]  dr_sync, rr_sync;
  logic        dr_evt, rr_evt;
  logic        we_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  hi_q;
  logic        byte_state;

  assign dr_evt     = dr_sync[1] & ~dr_sync[2];
  assign rr_evt     = rr_sync[1] & ~rr_sync[2];
  assign byte_state = (state != IDLE) && (state != DONE);

  // Synchronize the asynchronous handshakes and keep one cycle of history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dr_sync <= '0;
      rr_sync <= '0;
    end else begin
      dr_sync <= {dr_sync[1:0], ard_data_ready};
      rr_sync <= {rr_sync[1:0], ard_receive_ready};
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_abort;
  logic          err_q;

  // Stall timer restarts on every state change and runs only in byte states
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_abort;
      if ((state_nxt != state) || !byte_state) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign rsp_err = (state == DONE) && err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign rsp_err    = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; a handshake event not matching the current state is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ADDR_HI;
      ADDR_HI: if (rr_evt) state_nxt = ADDR_LO;
      ADDR_LO: if (rr_evt) state_nxt = we_q ? WR_HI : RD_HI;
      WR_HI:   if (rr_evt) state_nxt = WR_LO;
      WR_LO:   if (rr_evt) state_nxt = DONE;
      RD_HI:   if (dr_evt) state_nxt = RD_LO;
      RD_LO:   if (dr_evt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef BRIDGE_TIMEOUT_EN
    // A handshake arriving on the last allowed cycle still wins
    tmo_abort = byte_state && (state_nxt == state) &&
                (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    if (tmo_abort) state_nxt = DONE;
`endif
  end

  // Byte-lane outputs decoded from the state
  always_comb begin
    out_bus = 8'h00;
    bus_mar = 1'b0;
    bus_mdr = 1'b0;
    case (state)
      ADDR_HI: begin out_bus = addr_q[15:8];  bus_mar = 1'b1; end
      ADDR_LO: begin out_bus = addr_q[7:0];   bus_mar = 1'b1; end
      WR_HI:   begin out_bus = wdata_q[15:8]; bus_mdr = 1'b1; end
      WR_LO:   begin out_bus = wdata_q[7:0];  bus_mdr = 1'b1; end
      RD_HI, RD_LO: bus_mdr = 1'b1;
      default: ;
    endcase
  end

  // Request latch and read-data capture; rdata only moves on a read completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == RD_HI && dr_evt) hi_q <= in_bus;
      if (state == RD_LO && dr_evt) rdata_q <= {hi_q, in_bus};
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign bus_we    = (state != IDLE) && we_q;
  assign rsp_rdata = rdata_q;

endmodule
